// File: rtl/fpu_parser_pkg.sv
// Shared opcode encoding, instruction field positions and sticky-error bit
// positions for the co-processor instruction parser.
package fpu_parser_pkg;

  typedef enum logic [3:0] {
    NOP    = 4'h0,
    STORE2 = 4'h1,
    LOAD   = 4'h2,
    ADD    = 4'h3,
    SUB    = 4'h4,
    MUL    = 4'h5,
    SIN    = 4'h6,
    NEG    = 4'h7,
    ABS    = 4'h8,
    MOVE   = 4'h9,
    STORE1 = 4'hA
  } opcode_t;

  localparam int OPCODE_MSB   = 31;
  localparam int OPCODE_LSB   = 28;
  localparam int DEST_LSB     = 24;
  localparam int INSTR_MSB    = 31;
  localparam int INSTR_LSB    = 16;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_SATURATE  = 1;
  localparam int ERR_HAZARD    = 2;
  localparam int ERR_UNDERFLOW = 3;

  // Opcodes that write a destination register and therefore own a scoreboard slot.
  function automatic logic is_dest_op(input logic [3:0] op);
    case (op)
      LOAD, ADD, SUB, MUL, SIN, NEG, ABS, MOVE: is_dest_op = 1'b1;
      default:                                  is_dest_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/scoreboard_counter.sv
// Saturating pending-write counter for one architectural register.
// Simultaneous inc and dec cancel; dec at zero is dropped and flagged.
module scoreboard_counter #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 at_max,
  output logic                 underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] count_q, count_d;

  assign count     = count_q;
  assign at_max    = (count_q == CNT_MAX);
  assign underflow = dec && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (inc && !dec && !at_max)
      count_d = count_q + 1'b1;
    else if (dec && !inc && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/scoreboard_instr_parser.sv
// Instruction front end: decodes master writes, buffers STORE1 operands,
// tracks pending register writes. Option macro: SCOREBOARD_HAZARD_STALL_EN.
module scoreboard_instr_parser #(
  parameter int NUM_REGS   = 16,
  parameter int CNT_WIDTH  = 4,
  parameter int DATA_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   addr_bus,
  input  logic [DATA_WIDTH-1:0]         data_bus,
  input  logic                          valid,
  input  logic                          wr_req,
  input  logic [NUM_REGS-1:0]           dep_clear,
  input  logic                          instr_full,
  input  logic                          rd_data_en,
  input  logic                          err_clear,
  output logic [15:0]                   instr_out,
  output logic                          instr_push,
  output logic [$clog2(NUM_REGS)-1:0]   out_reg,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [$clog2(DATA_DEPTH):0]   data_count,
  output logic [NUM_REGS-1:0]           busy_map,
  output logic                          rd_stall,
  output logic                          wr_error,
  output logic                          rd_error,
  output logic [3:0]                    err_status
);

  import fpu_parser_pkg::*;

  localparam int REG_BITS = $clog2(NUM_REGS);
  localparam int PTR_W    = $clog2(DATA_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(DATA_DEPTH);

  logic [3:0]          opcode;
  logic [REG_BITS-1:0] dest;
  logic                wr_cyc, rd_cyc, dest_op, is_store1;
  logic                reject_ovf, reject_sat, accept, hazard;
  logic                fifo_push, fifo_pop, pop_empty;
  logic [3:0]          err_set, err_status_d;
  logic                unused_addr_bits;

  logic [NUM_REGS-1:0]  at_max_vec, underflow_vec, inc_vec;
  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q, count_d;

  logic [15:0] instr_out_q;
  logic        instr_push_q, wr_error_q, rd_error_q;
  logic [3:0]  err_status_q;

  assign opcode  = addr_bus[OPCODE_MSB:OPCODE_LSB];
  assign dest    = addr_bus[DEST_LSB+REG_BITS-1:DEST_LSB];
  assign out_reg = addr_bus[REG_BITS-1:0];
  assign unused_addr_bits = ^addr_bus[15:REG_BITS];

  assign dest_op   = is_dest_op(opcode);
  assign is_store1 = (opcode == STORE1);
  assign wr_cyc    = valid && wr_req && !instr_full;
  assign rd_cyc    = valid && !wr_req;

  // A same-cycle pop frees a slot, so a STORE1 into a full FIFO is still legal then.
  assign reject_ovf = wr_cyc && is_store1 && (count_q == FIFO_FULL) && !rd_data_en;
  assign reject_sat = wr_cyc && dest_op && at_max_vec[dest] && !dep_clear[dest];
  assign accept     = wr_cyc && !reject_ovf && !reject_sat;

  assign fifo_push = accept && is_store1;
  assign fifo_pop  = rd_data_en && (count_q != '0);
  assign pop_empty = rd_data_en && (count_q == '0);
  assign count_d   = count_q + {{PTR_W{1'b0}}, fifo_push} - {{PTR_W{1'b0}}, fifo_pop};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      assign inc_vec[gi] = accept && dest_op && (dest == REG_BITS'(gi));
      scoreboard_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc_vec[gi]),
        .dec       (dep_clear[gi]),
        .count     (cnt[gi]),
        .at_max    (at_max_vec[gi]),
        .underflow (underflow_vec[gi])
      );
      assign busy_map[gi] = |cnt[gi];
    end
  endgenerate

  // Hazard looks at the counters as they stand this cycle, before any update.
  assign hazard = rd_cyc && busy_map[out_reg];

`ifdef SCOREBOARD_HAZARD_STALL_EN
  assign rd_stall = hazard;
  assign err_set[ERR_HAZARD] = 1'b0;
`else
  assign rd_stall = 1'b0;
  assign err_set[ERR_HAZARD] = hazard;
`endif
  assign err_set[ERR_OVERFLOW]  = reject_ovf;
  assign err_set[ERR_SATURATE]  = reject_sat;
  assign err_set[ERR_UNDERFLOW] = (|underflow_vec) || pop_empty;
  assign err_status_d = (err_clear ? 4'b0000 : err_status_q) | err_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out_q  <= '0;
      instr_push_q <= 1'b0;
      wr_error_q   <= 1'b0;
      rd_error_q   <= 1'b0;
      err_status_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < DATA_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      instr_push_q <= accept;
      if (accept) instr_out_q <= addr_bus[INSTR_MSB:INSTR_LSB];
      wr_error_q   <= reject_ovf || reject_sat;
      rd_error_q   <= err_set[ERR_HAZARD];
      err_status_q <= err_status_d;
      if (fifo_push) begin
        mem_q[wr_ptr_q] <= data_bus;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign instr_out  = instr_out_q;
  assign instr_push = instr_push_q;
  assign wr_error   = wr_error_q;
  assign rd_error   = rd_error_q;
  assign err_status = err_status_q;
  assign rd_data    = mem_q[rd_ptr_q];
  assign data_count = count_q;

endmodule

// File: tb/tb_scoreboard_instr_parser.sv
// Directed bench for scoreboard_instr_parser (CNT_WIDTH=2, DATA_DEPTH=4);
// hazard checks follow SCOREBOARD_HAZARD_STALL_EN if defined.
module tb_scoreboard_instr_parser;

  localparam int NUM_REGS   = 16;
  localparam int CNT_WIDTH  = 2;
  localparam int DATA_DEPTH = 4;
  localparam int DATA_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [31:0]           addr_bus;
  logic [DATA_WIDTH-1:0] data_bus;
  logic                  valid, wr_req, instr_full, rd_data_en, err_clear;
  logic [NUM_REGS-1:0]   dep_clear;
  logic [15:0]           instr_out;
  logic                  instr_push, rd_stall, wr_error, rd_error;
  logic [3:0]            out_reg;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [2:0]            data_count;
  logic [NUM_REGS-1:0]   busy_map;
  logic [3:0]            err_status;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  scoreboard_instr_parser #(
    .NUM_REGS(NUM_REGS), .CNT_WIDTH(CNT_WIDTH),
    .DATA_DEPTH(DATA_DEPTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
    .valid(valid), .wr_req(wr_req), .dep_clear(dep_clear),
    .instr_full(instr_full), .rd_data_en(rd_data_en), .err_clear(err_clear),
    .instr_out(instr_out), .instr_push(instr_push), .out_reg(out_reg),
    .rd_data(rd_data), .data_count(data_count), .busy_map(busy_map),
    .rd_stall(rd_stall), .wr_error(wr_error), .rd_error(rd_error),
    .err_status(err_status)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic idle();
    addr_bus = '0; data_bus = '0; valid = 0; wr_req = 0;
    dep_clear = '0; instr_full = 0; rd_data_en = 0; err_clear = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_bus = a; data_bus = d; valid = 1; wr_req = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    check("reset_push", instr_push, 0);
    check("reset_instr_out", instr_out, 0);
    check("reset_errs", {wr_error, rd_error, rd_stall}, 0);
    check("reset_status", err_status, 0);
    check("reset_busy", busy_map, 0);
    check("reset_count", data_count, 0);

    // ADD dest=5, then a read of r5 hits the hazard
    wr(32'h3500_0000, 0); step(); idle();
    check("add_push", instr_push, 1);
    check("add_instr_out", instr_out, 16'h3500);
    check("add_busy", busy_map, 16'h0020);
    check("add_wr_error", wr_error, 0);
    step();
    check("add_push_once", instr_push, 0);
    addr_bus = 32'h0000_0005; valid = 1; #1;
    check("rd_out_reg", out_reg, 5);
`ifdef SCOREBOARD_HAZARD_STALL_EN
    check("rd_stall_r5", rd_stall, 1);
    step(); idle();
    check("rd_error_r5", rd_error, 0);
    check("rd_status_r5", err_status, 4'b0000);
`else
    check("rd_stall_r5", rd_stall, 0);
    step(); idle();
    check("rd_error_r5", rd_error, 1);
    check("rd_status_r5", err_status, 4'b0100);
`endif
    dep_clear = 16'h0020; step(); idle();
    check("clr5_busy", busy_map, 0);
    check("clr5_rd_error", rd_error, 0);
    err_clear = 1; step(); idle();
    check("errclr_status", err_status, 0);

    // Five STORE1 into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      wr(32'hA000_0000, 32'h1000 + i); step();
      check($sformatf("st1_%0d_wr_error", i), wr_error, (i == 4));
      check($sformatf("st1_%0d_count", i), data_count, (i < 4) ? i + 1 : 4);
    end
    idle();
    check("st1_ovf_status", err_status, 4'b0001);
    check("st1_head", rd_data, 32'h1000);
    rd_data_en = 1; step(); idle();
    check("pop_head", rd_data, 32'h1001);
    check("pop_count", data_count, 3);
    wr(32'hA000_0000, 32'h2000); step(); idle();
    check("refill_count", data_count, 4);
    err_clear = 1; step(); idle();
    wr(32'hA000_0000, 32'h2001); rd_data_en = 1; step(); idle();
    check("fullpp_wr_error", wr_error, 0);
    check("fullpp_push", instr_push, 1);
    check("fullpp_count", data_count, 4);
    check("fullpp_head", rd_data, 32'h1002);
    check("fullpp_status", err_status, 0);
    begin
      logic [31:0] drain [4];
      drain[0] = 32'h1002; drain[1] = 32'h1003; drain[2] = 32'h2000; drain[3] = 32'h2001;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("drain_%0d", i), rd_data, drain[i]);
        rd_data_en = 1; step(); idle();
      end
    end
    check("drain_count", data_count, 0);
    check("empty_head", rd_data, 32'h1002);
    rd_data_en = 1; step(); idle();
    check("pop_empty_status", err_status, 4'b1000);
    check("pop_empty_head", rd_data, 32'h1002);
    check("pop_empty_count", data_count, 0);
    err_clear = 1; step(); idle();

    // Counter saturation on r3 (max 3)
    for (int i = 0; i < 4; i++) begin
      wr(32'h5300_0000, 0); step();
      check($sformatf("mul_%0d_push", i), instr_push, (i < 3));
      check($sformatf("mul_%0d_wr_error", i), wr_error, (i == 3));
    end
    idle();
    check("mul_sat_status", err_status, 4'b0010);
    wr(32'h5300_0000, 0); dep_clear = 16'h0008; step(); idle();
    check("mul_clr_push", instr_push, 1);
    check("mul_clr_wr_error", wr_error, 0);
    for (int i = 0; i < 3; i++) begin
      dep_clear = 16'h0008; step(); idle();
      check($sformatf("mul_drain_%0d_busy", i), busy_map[3], (i < 2));
    end

    // SUB r7 with a same-cycle clear leaves the counter at 1
    wr(32'h4700_0000, 0); step(); idle();
    wr(32'h4700_0000, 0); dep_clear = 16'h0080; step(); idle();
    check("sub_clr_busy", busy_map, 16'h0080);
    dep_clear = 16'h0080; step(); idle();
    check("sub_final_busy", busy_map, 0);

    // Underflow and err_clear priority
    err_clear = 1; step(); idle();
    dep_clear = 16'h0004; step(); idle();
    check("uflow_status", err_status, 4'b1010 & 4'b1000);
    dep_clear = 16'h0004; err_clear = 1; step(); idle();
    check("clr_vs_set_status", err_status, 4'b1000);
    err_clear = 1; step(); idle();
    check("clr_only_status", err_status, 0);

    // Instruction FIFO full: write ignored silently
    wr(32'h3600_0000, 0); instr_full = 1; step(); idle();
    check("ifull_push", instr_push, 0);
    check("ifull_wr_error", wr_error, 0);
    check("ifull_busy", busy_map, 0);

    // Undefined opcode pushed without side effects
    wr(32'hF123_0000, 0); step(); idle();
    check("undef_push", instr_push, 1);
    check("undef_instr_out", instr_out, 16'hF123);
    check("undef_busy", busy_map, 0);

    // Hazard on r9 and its release
    wr(32'h2900_0000, 0); step(); idle();
    addr_bus = 32'h0000_0009; valid = 1; #1;
`ifdef SCOREBOARD_HAZARD_STALL_EN
    check("r9_stall", rd_stall, 1);
    dep_clear = 16'h0200; step();
    check("r9_rd_error", rd_error, 0);
    dep_clear = '0; #1;
    check("r9_stall_released", rd_stall, 0);
    idle();
`else
    check("r9_stall", rd_stall, 0);
    step(); idle();
    check("r9_rd_error", rd_error, 1);
    dep_clear = 16'h0200; step(); idle();
    check("r9_busy_released", busy_map, 0);
`endif

    // Reset in the middle of a STORE1 burst
    wr(32'hA000_0000, 32'hDEAD_0001); step();
    wr(32'hA000_0000, 32'hDEAD_0002); dep_clear = 16'h0001; step();
    wr(32'hA000_0000, 32'hDEAD_0003); rst = 1; step(); idle(); rst = 0;
    check("rst_mid_push", instr_push, 0);
    check("rst_mid_count", data_count, 0);
    check("rst_mid_rd_data", rd_data, 0);
    check("rst_mid_status", err_status, 0);
    check("rst_mid_outs", {instr_out, wr_error, rd_error}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/scoreboard_instr_parser.md
Name: scoreboard_instr_parser

Overview:
Parametrised front end of the floating-point co-processor. It decodes bus-master instruction writes and forwards accepted instructions to the instruction FIFO. STORE1 operands are buffered in an internal data FIFO. A per-register scoreboard of saturating pending-write counters flags or stalls master reads of registers that still have writes outstanding. All errors are registered and latched in a sticky status vector that the master can clear.

Parameters:
NUM_REGS, 16, number of architectural registers (power of 2, 2..16); REG_BITS = $clog2(NUM_REGS)
CNT_WIDTH, 4, width of each pending-write counter; saturates at 2**CNT_WIDTH-1
DATA_DEPTH, 4, STORE1 data FIFO entries (power of 2, >=2)
DATA_WIDTH, 32, data bus / operand width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
addr_bus  in  32  instruction word; [31:28] opcode, [27:24] dest, [REG_BITS-1:0] read register
data_bus  in  DATA_WIDTH  STORE1 operand
valid  in  1  bus cycle qualifier
wr_req  in  1  1 = instruction write, 0 = register read
dep_clear  in  NUM_REGS  one-hot-per-bit completion from ALU; decrements counter i
instr_full  in  1  instruction FIFO full
rd_data_en  in  1  pop data FIFO (store unit)
err_clear  in  1  clear sticky status
instr_out  out  16  registered addr_bus[31:16] of accepted instruction
instr_push  out  1  registered one-cycle push strobe to instruction FIFO
out_reg  out  REG_BITS  combinational addr_bus[REG_BITS-1:0]
rd_data  out  DATA_WIDTH  data FIFO head
data_count  out  $clog2(DATA_DEPTH)+1  data FIFO occupancy
busy_map  out  NUM_REGS  bit i = counter i nonzero
rd_stall  out  1  hazard stall (see Optional Feature)
wr_error  out  1  registered pulse: write rejected
rd_error  out  1  registered pulse: read hazard
err_status  out  4  sticky: [0] data overflow, [1] counter saturation, [2] read hazard, [3] underflow

Behaviour:
- Reset: all counters 0; FIFO empty; instr_out, instr_push, wr_error, rd_error, err_status = 0. Reset aborts any pending push.
- Write request: wr_cyc = valid & wr_req & !instr_full. Valid & wr_req while instr_full is ignored (no error, no state change).
- Destination opcodes LOAD, ADD, SUB, MUL, SIN, NEG, ABS and MOVE use dest = addr_bus[24+REG_BITS-1:24].
- Rejection on wr_cyc:
  - STORE1 with FIFO full, unless rd_data_en pops in the same cycle: reject, set err_status[0].
  - Destination opcode whose dest counter is at max and dep_clear[dest]=0: reject, set err_status[1].
- Reject response: wr_error=1 in the next cycle; nothing pushed, no counter change, no data written.
- Accept response:
  - instr_push=1 and instr_out=addr_bus[31:16] in the next cycle (latency 1).
  - STORE1 writes data_bus into the FIFO.
  - Destination opcodes increment the dest counter.
- NOP, STORE2 and undefined opcodes are pushed without side effects.
- Counters:
  - Increment and dep_clear in the same cycle: counter unchanged.
  - dep_clear on a zero counter: ignored, set err_status[3].
- Data FIFO:
  - Circular buffer, first-word fall-through; rd_data is the head.
  - Pop while empty: ignored, rd_data holds, set err_status[3].
  - Simultaneous push and pop while full is legal; count unchanged.
- Read request: valid & !wr_req. If busy_map[out_reg]=1, take the hazard path below. Hazard is evaluated on pre-update counters.
- err_status: bits OR in set events each cycle. err_clear zeroes all bits, but a set event in the same cycle wins for its own bit.

Optional Feature:
Macro: SCOREBOARD_HAZARD_STALL_EN
- Defined:
  - A read hazard drives rd_stall=1 combinationally for as long as the condition holds.
  - rd_error stays 0 and err_status[2] is never set; the master is expected to retry.
- Undefined:
  - rd_stall is tied 0.
  - A read hazard gives rd_error=1 in the next cycle and sets err_status[2].

Decomposition:
- Package fpu_parser_pkg holds:
  - opcode_t enum: NOP=0, STORE2=1, LOAD=2, ADD=3, SUB=4, MUL=5, SIN=6, NEG=7, ABS=8, MOVE=9, STORE1=A.
  - Field LSB/MSB constants.
  - Err_status bit index constants.
  - is_dest_op() function.
- Sub-module scoreboard_counter: saturating up/down counter with CNT_WIDTH, inc, dec, count, at_max, underflow. Instantiated NUM_REGS times in a generate loop.

Test Plan:
- Reset, then ADD dest=5 accepted -> next cycle instr_push=1, instr_out=0x35xx, busy_map[5]=1. Read out_reg=5 -> rd_error next cycle, err_status=0b0100. dep_clear[5] -> busy_map[5]=0.
- Five STORE1 with DEPTH=4, no pops -> first four accepted (data_count=4), fifth gives wr_error=1 and err_status[0]. Repeat with rd_data_en on the fifth -> accepted, count stays 4.
- CNT_WIDTH=2: four MUL dest=3 -> first three accepted, fourth rejected with err_status[1]. Fourth with dep_clear[3] in the same cycle -> accepted, count stays 3.
- Simultaneous SUB dest=7 and dep_clear[7] with counter=1 -> counter stays 1. dep_clear[2] at zero -> err_status[3]. err_clear -> 0. err_clear in the same cycle as a new set event -> that bit remains 1.
- instr_full=1 with valid write -> no push, no wr_error. rst asserted mid-STORE1 sequence -> FIFO empty, all outputs 0 next cycle.
- With SCOREBOARD_HAZARD_STALL_EN: read of busy reg 9 -> rd_stall=1 same cycle, rd_error=0. After dep_clear[9] -> rd_stall=0.
